gpio_bus_arbiter: RTL

Two-requester round-robin arbiter that shares the single GPIOS peripheral bus port (read/write/address/write_data/read_data) between the CPU data port (requester 0) and a secondary master such as a debug or DMA unit (requester 1).
- Serialises accesses, one transaction in flight.
- Issues a one-cycle peripheral strobe per transaction.
- Waits a fixed read latency, then returns data and a one-cycle acknowledge to the winning requester.
- Sits between the interconnect and GPIOS; no decoding of GPIO register semantics.

---
 rtl/gpio_bus_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gpio_bus_arbiter.sv
// rtl/gpio_bus_arbiter.sv - two-requester round-robin arbiter for the GPIOS peripheral bus
module gpio_bus_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1    // strobe-to-data cycles, 1..15
) (
    input  logic                  clk,
    input  logic                  reset,          // synchronous, active high

    // requester 0 (CPU data port)
    input  logic                  r0_read,
    input  logic                  r0_write,
    input  logic [ADDR_WIDTH-1:0] r0_address,
    input  logic [DATA_WIDTH-1:0] r0_write_data,
    output logic [DATA_WIDTH-1:0] r0_read_data,
    output logic                  r0_ack,

    // requester 1 (debug / DMA master)
    input  logic                  r1_read,
    input  logic                  r1_write,
    input  logic [ADDR_WIDTH-1:0] r1_address,
    input  logic [DATA_WIDTH-1:0] r1_write_data,
    output logic [DATA_WIDTH-1:0] r1_read_data,
    output logic                  r1_ack,

    // shared peripheral port
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,

    // status
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    // WAIT is entered with this value and ends on zero, giving READ_LATENCY cycles
    localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 1);

    state_t     state;
    logic       last_grant;
    logic       op_write;
    logic [3:0] wait_cnt;

    logic       req0;
    logic       req1;
    logic       pick;

    // A tie goes to the requester that did not win last time
    always_comb begin
        req0 = r0_read | r0_write;
        req1 = r1_read | r1_write;
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else begin
            pick = req1;
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            op_write     <= 1'b0;
            wait_cnt     <= 4'd0;
            address      <= '0;
            write_data   <= '0;
            read         <= 1'b0;
            write        <= 1'b0;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            r0_read_data <= '0;
            r1_read_data <= '0;
        end else begin
            // strobes and acks are single-cycle pulses
            read   <= 1'b0;
            write  <= 1'b0;
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        grant_id   <= pick;
                        last_grant <= pick;
                        // write wins when a requester raises both read and write;
                        // the strobe is registered here so it is high during ISSUE
                        if (pick) begin
                            address    <= r1_address;
                            write_data <= r1_write_data;
                            op_write   <= r1_write;
                            write      <= r1_write;
                            read       <= ~r1_write;
                        end else begin
                            address    <= r0_address;
                            write_data <= r0_write_data;
                            op_write   <= r0_write;
                            write      <= r0_write;
                            read       <= ~r0_write;
                        end
                        state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (op_write) begin
                        if (grant_id) begin
                            r1_ack <= 1'b1;
                        end else begin
                            r0_ack <= 1'b1;
                        end
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        if (grant_id) begin
                            r1_read_data <= read_data;
                            r1_ack       <= 1'b1;
                        end else begin
                            r0_read_data <= read_data;
                            r0_ack       <= 1'b1;
                        end
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                S_ACK: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
